// File: rtl/or1200_vlx_pkg.sv
// ============================================================================
// or1200_vlx_pkg : shared types and constants for the VLX store sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package or1200_vlx_pkg;

  typedef enum logic [1:0] {
    VLX_IDLE  = 2'd0,
    VLX_WRITE = 2'd1,
    VLX_STUFF = 2'd2,
    VLX_DONE  = 2'd3
  } vlx_seq_state_t;

  localparam logic [7:0]  VLX_STUFF_MARK = 8'hFF;
  localparam logic [7:0]  VLX_STUFF_BYTE = 8'h00;
  localparam int unsigned VLX_MAX_BYTES  = 4;

  function automatic logic [2:0] vlx_clamp_nbytes(input logic [2:0] n);
    return (n > 3'(VLX_MAX_BYTES)) ? 3'(VLX_MAX_BYTES) : n;
  endfunction

  // Byte 0 of a group sits in [31:24].
  function automatic logic [7:0] vlx_byte_at(input logic [31:0] d, input logic [1:0] idx);
    logic [31:0] s;
    s = d << {idx, 3'b000};
    return s[31:24];
  endfunction

endpackage

`default_nettype wire

// File: rtl/or1200_vlx_lane_steer.sv
// ============================================================================
// or1200_vlx_lane_steer : big-endian byte lane select and data replication
// Revision 1.0
// ============================================================================
`default_nettype none

module or1200_vlx_lane_steer (
  input  logic [7:0]  byte_i,
  input  logic [1:0]  addr_lo_i,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o
);

  assign sel_o = 4'b1000 >> addr_lo_i;
  assign dat_o = {4{byte_i}};

endmodule

`default_nettype wire

// File: rtl/or1200_vlx_store_seq.sv
// ============================================================================
// or1200_vlx_store_seq : issues VLX byte groups as single-byte Wishbone writes
// Revision 1.0
// ============================================================================
`default_nettype none

module or1200_vlx_store_seq
  import or1200_vlx_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_addr_we_i,
  input  logic [ADDR_W-1:0] init_addr_i,
  input  logic              stuff_en_i,
  input  logic              req_i,
  input  logic [2:0]        req_nbytes_i,
  input  logic [31:0]       req_data_i,
  output logic              req_ready_o,
  output logic              stall_cpu_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [CNT_W-1:0]  byte_cnt_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [31:0]       wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

  vlx_seq_state_t    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        nb_q, nb_d;
  logic [1:0]        idx_q, idx_d;
  logic              stuff_q, stuff_d;
  logic              done_q;
  logic              cyc_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_q;
  logic [7:0]        byte_d;

  logic [7:0]  w_cur_byte;
  logic [7:0]  w_next_byte;
  logic        w_more;
  logic        w_active_d;
  logic [3:0]  w_sel;
  logic [31:0] w_dat;

  assign w_cur_byte  = vlx_byte_at(data_q, idx_q);
  assign w_next_byte = vlx_byte_at(data_q, idx_q + 2'd1);
  assign w_more      = (({1'b0, idx_q}) + 3'd1) < nb_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = data_q;
    nb_d    = nb_q;
    idx_d   = idx_q;
    stuff_d = stuff_q;
    byte_d  = 8'h00;
    unique case (state_q)
      VLX_IDLE: begin
        // An address load takes priority; a concurrent request stays pending.
        if (init_addr_we_i) begin
          addr_d = init_addr_i;
          cnt_d  = '0;
          err_d  = 1'b0;
        end else if (req_i && (req_nbytes_i != 3'd0)) begin
          data_d  = req_data_i;
          nb_d    = vlx_clamp_nbytes(req_nbytes_i);
          stuff_d = stuff_en_i;
          idx_d   = 2'd0;
          byte_d  = req_data_i[31:24];
          state_d = VLX_WRITE;
        end
      end
      VLX_WRITE: begin
        byte_d = w_cur_byte;
        if (wb_err_i) begin
          err_d   = 1'b1;
          state_d = VLX_DONE;
        end else if (wb_ack_i) begin
          addr_d = addr_q + c_addr_one;
          cnt_d  = cnt_q + c_cnt_one;
          if ((w_cur_byte == VLX_STUFF_MARK) && stuff_q) begin
            byte_d  = VLX_STUFF_BYTE;
            state_d = VLX_STUFF;
          end else if (w_more) begin
            idx_d  = idx_q + 2'd1;
            byte_d = w_next_byte;
          end else begin
            state_d = VLX_DONE;
          end
        end
      end
      VLX_STUFF: begin
        byte_d = VLX_STUFF_BYTE;
        if (wb_err_i) begin
          err_d   = 1'b1;
          state_d = VLX_DONE;
        end else if (wb_ack_i) begin
          addr_d = addr_q + c_addr_one;
          cnt_d  = cnt_q + c_cnt_one;
          if (w_more) begin
            idx_d   = idx_q + 2'd1;
            byte_d  = w_next_byte;
            state_d = VLX_WRITE;
          end else begin
            state_d = VLX_DONE;
          end
        end
      end
      VLX_DONE: state_d = VLX_IDLE;
      default:  state_d = VLX_IDLE;
    endcase
  end

  assign w_active_d = (state_d == VLX_WRITE) || (state_d == VLX_STUFF);

  // Steering is fed next-state byte/address so the bus lanes come out registered.
  or1200_vlx_lane_steer u_steer (
    .byte_i    (byte_d),
    .addr_lo_i (addr_d[1:0]),
    .sel_o     (w_sel),
    .dat_o     (w_dat)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= VLX_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      nb_q    <= '0;
      idx_q   <= '0;
      stuff_q <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
      nb_q    <= nb_d;
      idx_q   <= idx_d;
      stuff_q <= stuff_d;
      done_q  <= (state_d == VLX_DONE);
      cyc_q   <= w_active_d;
      sel_q   <= w_active_d ? w_sel : 4'b0000;
      dat_q   <= w_active_d ? w_dat : 32'h0;
    end
  end

  generate
    if (ADDR_W >= 32) begin : g_adr_full
      assign wb_adr_o = addr_q[31:0];
    end else begin : g_adr_ext
      assign wb_adr_o = {{(32-ADDR_W){1'b0}}, addr_q};
    end
  endgenerate

  assign req_ready_o = (state_q == VLX_IDLE) && !init_addr_we_i;
  assign stall_cpu_o = ((state_q != VLX_IDLE) && (state_q != VLX_DONE)) ||
                       ((state_q == VLX_IDLE) && req_i && (req_nbytes_i != 3'd0));
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign addr_o      = addr_q;
  assign byte_cnt_o  = cnt_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = cyc_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = dat_q;

endmodule

`default_nettype wire

// File: tb/tb_or1200_vlx_store_seq.sv
// ============================================================================
// tb_or1200_vlx_store_seq : directed scoreboard bench for the VLX store sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_or1200_vlx_store_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_we = 1'b0;
  logic [31:0] init_addr = '0;
  logic        stuff_en = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  nbytes = '0;
  logic [31:0] rdata = '0;
  logic        req_ready, stall, done, err;
  logic [31:0] addr;
  logic [15:0] cnt;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;

  or1200_vlx_store_seq #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .init_addr_we_i (init_we),
    .init_addr_i    (init_addr),
    .stuff_en_i     (stuff_en),
    .req_i          (req),
    .req_nbytes_i   (nbytes),
    .req_data_i     (rdata),
    .req_ready_o    (req_ready),
    .stall_cpu_o    (stall),
    .done_o         (done),
    .err_o          (err),
    .addr_o         (addr),
    .byte_cnt_o     (cnt),
    .wb_cyc_o       (wb_cyc),
    .wb_stb_o       (wb_stb),
    .wb_we_o        (wb_we),
    .wb_adr_o       (wb_adr),
    .wb_sel_o       (wb_sel),
    .wb_dat_o       (wb_dat),
    .wb_ack_i       (wb_ack),
    .wb_err_i       (wb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         w;
  int          n_tests = 0;
  int          n_fail = 0;
  int          waits = 0;
  int          err_beat = 0;
  int          beat = 0;
  int          wcnt = 0;
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic [31:0] m_addr = '0;
  logic [15:0] m_cnt = '0;
  logic        m_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wishbone slave: programmable wait states, optional error on one beat.
  always @(negedge clk) begin
    if (rst_n && wb_cyc && wb_stb) begin
      if (wcnt == 0) begin
        cap_adr = wb_adr;
        cap_dat = wb_dat;
        cap_sel = wb_sel;
      end else begin
        check("stable_adr", 64'(wb_adr), 64'(cap_adr));
        check("stable_dat", 64'(wb_dat), 64'(cap_dat));
        check("stable_sel", 64'(wb_sel), 64'(cap_sel));
      end
      if (wcnt >= waits) begin
        beat++;
        check("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("wr_adr", 64'(wb_adr), 64'(w.adr));
          check("wr_sel", 64'(wb_sel), 64'(w.sel));
          check("wr_dat", 64'(wb_dat), 64'(w.dat));
          check("wr_we",  64'(wb_we),  64'd1);
        end
        wb_err = (beat == err_beat);
        wb_ack = (beat != err_beat);
        wcnt   = 0;
      end else begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        wcnt++;
      end
    end else begin
      wb_ack = 1'b0;
      wb_err = 1'b0;
      wcnt   = 0;
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [7:0] b);
    wr_t e;
    e.adr = a;
    e.sel = 4'b1000 >> a[1:0];
    e.dat = {4{b}};
    exp_q.push_back(e);
  endtask

  task automatic init(input logic [31:0] a);
    @(negedge clk);
    init_we   = 1'b1;
    init_addr = a;
    #1 check("init_ready_low", 64'(req_ready), 64'd0);
    @(negedge clk);
    init_we = 1'b0;
    m_addr  = a;
    m_cnt   = '0;
    m_err   = 1'b0;
    check("init_addr", 64'(addr), 64'(m_addr));
    check("init_cnt",  64'(cnt),  64'(m_cnt));
    check("init_err",  64'(err),  64'(m_err));
  endtask

  task automatic send(input logic [2:0] n, input logic [31:0] d, input logic se);
    int          k;
    int          nbeats;
    int          cyc;
    bit          stop;
    bit          seen;
    logic [31:0] a;
    logic [7:0]  b;
    k      = (n > 3'd4) ? 4 : int'(n);
    nbeats = 0;
    stop   = 1'b0;
    a      = m_addr;
    for (int i = 0; i < k && !stop; i++) begin
      b = d[31-8*i -: 8];
      push_wr(a, b);
      nbeats++;
      if (nbeats == err_beat) stop = 1'b1;
      else begin
        a = a + 32'd1;
        if (b == 8'hFF && se) begin
          push_wr(a, 8'h00);
          nbeats++;
          if (nbeats == err_beat) stop = 1'b1;
          else a = a + 32'd1;
        end
      end
    end
    m_cnt  = m_cnt + 16'(a - m_addr);
    m_addr = a;
    if (stop) m_err = 1'b1;
    beat = 0;

    @(negedge clk);
    req      = 1'b1;
    nbytes   = n;
    rdata    = d;
    stuff_en = se;
    #1;
    check("req_ready", 64'(req_ready), 64'd1);
    check("stall_accept", 64'(stall), 64'd1);
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req    = 1'b0;
        nbytes = 3'd0;
      end
      if (done) begin
        seen = 1'b1;
        check("stall_done", 64'(stall), 64'd0);
        check("bus_idle_done", 64'(wb_cyc), 64'd0);
      end else begin
        check("stall_busy", 64'(stall), 64'd1);
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(cyc), 64'(nbeats * (waits + 1) + 1));
    check("addr_after", 64'(addr), 64'(m_addr));
    check("cnt_after",  64'(cnt),  64'(m_cnt));
    check("err_after",  64'(err),  64'(m_err));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("ready_again", 64'(req_ready), 64'd1);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_cyc",   64'(wb_cyc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_done", 64'(done), 64'd0);
    check("rst_err",  64'(err), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_cnt",  64'(cnt), 64'd0);
    check("rst_stb",  64'(wb_stb), 64'd0);
    check("rst_sel",  64'(wb_sel), 64'd0);
    check("rst_dat",  64'(wb_dat), 64'd0);
    check("rst_adr",  64'(wb_adr), 64'd0);

    // Address load collides with a request: load wins, request not taken
    @(negedge clk);
    init_we   = 1'b1;
    init_addr = 32'h1000;
    req       = 1'b1;
    nbytes    = 3'd3;
    rdata     = 32'h12345600;
    #1;
    check("collide_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    init_we = 1'b0;
    req     = 1'b0;
    nbytes  = 3'd0;
    check("collide_no_cyc", 64'(wb_cyc), 64'd0);
    check("collide_addr", 64'(addr), 64'h1000);
    m_addr = 32'h1000;
    m_cnt  = '0;

    send(3'd3, 32'h12345600, 1'b0);

    // Stuffing on / off
    init(32'h2003);
    send(3'd2, 32'hFFAB0000, 1'b1);
    init(32'h2003);
    send(3'd2, 32'hFFAB0000, 1'b0);

    // Wait states
    waits = 3;
    init(32'h2100);
    send(3'd2, 32'hA1B20000, 1'b0);
    waits = 0;

    // Bus error on second of four bytes
    init(32'h3000);
    err_beat = 2;
    send(3'd4, 32'h11223344, 1'b0);
    err_beat = 0;
    init(32'h3100);

    // Zero-byte request: nothing happens
    @(negedge clk);
    req    = 1'b1;
    nbytes = 3'd0;
    rdata  = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nb0_stall", 64'(stall), 64'd0);
      check("nb0_cyc",   64'(wb_cyc), 64'd0);
      @(negedge clk);
    end
    req = 1'b0;

    // Over-range count clamps to four
    send(3'd7, 32'hC0C1C2C3, 1'b0);

    // Address wrap
    init(32'hFFFF_FFFF);
    send(3'd2, 32'h5A6B0000, 1'b0);

    // Reset in the middle of a group
    waits = 5;
    init(32'h4000);
    @(negedge clk);
    req    = 1'b1;
    nbytes = 3'd3;
    rdata  = 32'h01020300;
    @(negedge clk);
    req    = 1'b0;
    nbytes = 3'd0;
    @(negedge clk);
    check("midrst_cyc_before", 64'(wb_cyc), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cyc", 64'(wb_cyc), 64'd0);
    check("midrst_stb", 64'(wb_stb), 64'd0);
    check("midrst_addr", 64'(addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    waits = 0;
    @(negedge clk);
    check("postrst_cyc", 64'(wb_cyc), 64'd0);
    check("postrst_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/or1200_vlx_store_seq.md
# or1200_vlx_store_seq

Store sequencer for the VLX (variable-length bit-packing) unit. It accepts groups of 1–4 completed bytes from the VLX datapath and issues them as single-byte Wishbone writes to consecutive addresses. When enabled, it inserts a JPEG 0x00 stuff byte after every 0xFF. It drives the CPU stall while a group is in flight, and it keeps the running output address that software programs and reads back through the VLX SPRs.

## Interface
Parameters:
- `ADDR_W`, default 32: width of the byte address.
- `CNT_W`, default 16: width of the written-byte counter.

Ports:
- `clk_i`  in  1  system clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `init_addr_we_i`  in  1  load the output address and clear `err_o` and `byte_cnt_o`.
- `init_addr_i`  in  ADDR_W  new output address.
- `stuff_en_i`  in  1  enables 0xFF→0xFF,0x00 stuffing; sampled at request acceptance.
- `req_i`  in  1  byte group request.
- `req_nbytes_i`  in  3  number of bytes in the group; 0 means no request; values above 4 are treated as 4.
- `req_data_i`  in  32  byte group, MSB first: byte 0 is `[31:24]`.
- `req_ready_o`  out  1  request is accepted in this cycle if `req_i` is also high.
- `stall_cpu_o`  out  1  CPU stall.
- `done_o`  out  1  one-cycle pulse when a group completes.
- `err_o`  out  1  sticky bus error flag.
- `addr_o`  out  ADDR_W  current output address, for SPR readback.
- `byte_cnt_o`  out  CNT_W  bytes written since the last init, stuff bytes included; wraps on overflow.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone master controls.
- `wb_adr_o`  out  32  byte address.
- `wb_sel_o`  out  4  byte lane select.
- `wb_dat_o`  out  32  write data.
- `wb_ack_i`, `wb_err_i`  in  1  Wishbone slave responses.

## Operation
States: IDLE, WRITE, STUFF, DONE.

IDLE:
- `req_ready_o` = 1 when `init_addr_we_i` = 0.
- On `req_i` & `req_nbytes_i`≠0 & `req_ready_o`: latch data, count (clamped to 4) and `stuff_en_i`; set byte index to 0; go to WRITE.

WRITE:
- Drive `cyc`/`stb`/`we` = 1. Present the current byte replicated on all four lanes.
- `wb_sel_o` = `4'b1000 >> addr[1:0]` (big-endian).
- On `wb_ack_i`: increment the address and `byte_cnt_o`.
  - If the byte is 0xFF and stuffing is latched, go to STUFF.
  - Otherwise, if more bytes remain, increment the index and stay in WRITE.
  - Otherwise go to DONE.

STUFF:
- Same bus drive as WRITE, with byte 0x00.
- On `wb_ack_i`: increment the address and count. Go to WRITE if bytes remain, otherwise to DONE.

DONE:
- `done_o` = 1 and the bus is idle. Return to IDLE next cycle.

Bus error:
- `wb_err_i` in WRITE or STUFF: set `err_o`, do not advance the address or count, drop the rest of the group, go to DONE. `done_o` still pulses.

Address and init:
- Address arithmetic is modulo 2^ADDR_W.
- `init_addr_we_i` outside IDLE is ignored.
- `init_addr_we_i` with `req_i` in IDLE: the load wins; the request is not accepted and must be held.

Stall:
- `stall_cpu_o` = (state ∉ {IDLE, DONE}) | (state==IDLE & `req_i` & `req_nbytes_i`≠0).
- The stall is high in the acceptance cycle and low again in the DONE cycle, so the CPU resumes on the cycle of the last ack + 1.

## Timing
Reset values:
- Outputs: all 0, except `req_ready_o` = 1.
- `addr_o` = 0; state = IDLE.
- Reset mid-transfer drops `cyc`/`stb` immediately and loses the group.

Latency:
- Acceptance at edge N; `stb` is high from cycle N+1.
- Each byte occupies `stb` until its ack. Back-to-back bytes keep `cyc`/`stb` continuously high; the address and data update on the ack edge.
- With zero-wait acks, a group of k bytes plus s stuff bytes gives `done_o` at cycle N+1+k+s.
- The earliest next acceptance is the cycle after `done_o`.

Output registering:
- All bus outputs are registered.
- `req_ready_o` and `stall_cpu_o` are combinational.

## Structure
- Package `or1200_vlx_pkg`:
  - state enum `vlx_seq_state_t`;
  - constants `VLX_STUFF_MARK` = 8'hFF, `VLX_STUFF_BYTE` = 8'h00, `VLX_MAX_BYTES` = 4.
- Sub-module `or1200_vlx_lane_steer` (combinational): byte plus `addr[1:0]` → `wb_sel_o` and `wb_dat_o`.
- Everything else lives in one FSM module.

## Test plan
- Init address 0x1000, then a request of 3 bytes 0x12345600 with zero-wait acks:
  - bus writes 0x12@0x1000 (sel 1000), 0x34@0x1001 (sel 0100), 0x56@0x1002 (sel 0010);
  - `done_o` at N+4; `addr_o` = 0x1003; `byte_cnt_o` = 3.
- Stuffing on, request of 2 bytes 0xFFAB0000 at 0x2003:
  - writes FF@0x2003 (sel 0001), 00@0x2004 (sel 1000), AB@0x2005;
  - `addr_o` = 0x2006.
- Same request with stuffing off: no 0x00 is written; `addr_o` ends at +2.
- Slave inserts 3 wait states per byte:
  - `stb`/`adr`/`dat` stay stable until the ack;
  - `stall_cpu_o` is high throughout and falls in the DONE cycle.
- `wb_err_i` on the 2nd of 4 bytes:
  - `err_o` = 1 and `done_o` pulses;
  - the address has advanced by 1 only;
  - a following `init_addr_we_i` clears `err_o`.
- Edge cases:
  - `req_nbytes_i` = 0 → no bus activity and no stall;
  - `req_nbytes_i` = 7 → 4 bytes written;
  - address 0xFFFFFFFF → wraps to 0;
  - `rst_i` low mid-group → `cyc`/`stb` drop in the same cycle.
